dm_responder: RTL and testbench

//   Target-side data memory for the multicycle CPU: a word-organised RAM that accepts

---
 rtl/dm_responder_if.sv | 23 ++
 rtl/dm_responder.sv | 119 +++++++++++
 tb/tb_dm_responder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dm_responder_if.sv
// rtl/dm_responder_if.sv - request/response channel bundle between CPU and data memory
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - wait-stated word RAM answering one load/store at a time
module dm_responder #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  dm_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  // The wait counter is only 4 bits, so larger settings cannot be honoured.
  if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_wait_cyc_check
    $error("dm_responder: WAIT_CYC must be in 0..15");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] rdata_q, rdata_next;
  logic        err_q, err_next;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic              accept;
  logic              access;
  logic              addr_err;
  logic              mem_we;
  logic [ADDR_W-1:0] word_idx;

  logic [31:0] mem [DEPTH];

  assign word_idx = lat_addr[ADDR_W+1:2];
  // Misaligned, or any address bit above the RAM's byte range set.
  assign addr_err = (lat_addr[1:0] != 2'b00) | (|(lat_addr >> (ADDR_W + 2)));
  assign accept   = (state == IDLE) && bus.req_valid;
  // A store still in BUSY when reset is sampled must never land in the RAM.
  assign mem_we   = access && lat_we && !addr_err && !rst;

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Next-state and response-data decode for the IDLE/BUSY/RESP sequence.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rdata_next = rdata_q;
    err_next   = err_q;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_next   = 4'(WAIT_CYC);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          access     = 1'b1;
          err_next   = addr_err;
          rdata_next = (addr_err || lat_we) ? 32'h0 : mem[word_idx];
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, wait counter and the registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      rdata_q <= rdata_next;
      err_q   <= err_next;
    end
  end

  // Request fields are captured only on the accept edge and held for the access.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      lat_we    <= bus.req_we;
      lat_addr  <= bus.req_addr;
      lat_wdata <= bus.req_wdata;
      lat_be    <= bus.req_be;
    end
  end

  // Byte-enabled store into the RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) begin
          mem[word_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - vector table plus corner sequences for dm_responder
module tb_dm_responder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dm_responder_if b0 ();
  dm_responder_if b1 ();

  dm_responder #(.ADDR_W(10), .WAIT_CYC(2)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  dm_responder #(.ADDR_W(10), .WAIT_CYC(0)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit s, input logic v, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    if (s) begin
      b1.req_valid = v; b1.req_we = we; b1.req_addr = addr; b1.req_wdata = wdata; b1.req_be = be;
    end else begin
      b0.req_valid = v; b0.req_we = we; b0.req_addr = addr; b0.req_wdata = wdata; b0.req_be = be;
    end
  endtask

  task automatic set_rsp_ready(input bit s, input logic v);
    if (s) b1.rsp_ready = v;
    else   b0.rsp_ready = v;
  endtask

  function automatic logic g_req_ready(input bit s);
    return s ? b1.req_ready : b0.req_ready;
  endfunction

  function automatic logic g_rsp_valid(input bit s);
    return s ? b1.rsp_valid : b0.rsp_valid;
  endfunction

  function automatic logic [31:0] g_rdata(input bit s);
    return s ? b1.rsp_rdata : b0.rsp_rdata;
  endfunction

  function automatic logic g_err(input bit s);
    return s ? b1.rsp_err : b0.rsp_err;
  endfunction

  // Called just after the accept edge; counts edges until rsp_valid is seen.
  task automatic wait_rsp(input bit s, output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (g_rsp_valid(s)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_rsp(input bit s, input string tag);
    set_rsp_ready(s, 1'b1);
    @(posedge clk);
    #1;
    set_rsp_ready(s, 1'b0);
    chk({tag, " rsp_valid after handshake"}, 32'(g_rsp_valid(s)), 32'd0);
    chk({tag, " req_ready after handshake"}, 32'(g_req_ready(s)), 32'd1);
  endtask

  task automatic txn(input bit s, input int wait_cyc, input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " req_ready idle"}, 32'(g_req_ready(s)), 32'd1);
    set_req(s, 1'b1, v.we, v.addr, v.wdata, v.be);
    @(posedge clk);
    #1;
    set_req(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk({tag, " req_ready busy"}, 32'(g_req_ready(s)), 32'd0);
    wait_rsp(s, lat);
    chk({tag, " latency"}, 32'(lat), 32'(wait_cyc + 1));
    chk({tag, " rdata"}, g_rdata(s), v.exp_rdata);
    chk({tag, " err"}, 32'(g_err(s)), 32'(v.exp_err));
    release_rsp(s, tag);
  endtask

  // Store whose BUSY phase is cut short by reset; the write must be dropped.
  task automatic store_with_reset(input bit s, input logic [31:0] addr, input logic [31:0] wdata,
                                  input string tag);
    @(negedge clk);
    set_req(s, 1'b1, 1'b1, addr, wdata, 4'hF);
    @(posedge clk);
    #1;
    set_req(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk({tag, " req_ready after rst"}, 32'(g_req_ready(s)), 32'd1);
    chk({tag, " rsp_valid after rst"}, 32'(g_rsp_valid(s)), 32'd0);
  endtask

  initial begin
    int lat;

    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'hDEAD_BEAA, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0010, 32'h1234_5678, 4'h0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'hDEAD_BEAA, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0012, 32'h0,        4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h0000_1000, 32'h1111_1111, 4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,        4'hF, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h0000_0024, 32'h0000_0000, 4'h6, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h0000_0024, 32'h0,        4'hF, 32'hFF00_00FF, 1'b0});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'h0,        4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'h0BAD_CAFE, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,        4'hF, 32'h0BAD_CAFE, 1'b0});

    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_rsp_ready(1'b0, 1'b0);
    set_rsp_ready(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset req_ready", 32'(g_req_ready(s[0])), 32'd1);
      chk("reset rsp_valid", 32'(g_rsp_valid(s[0])), 32'd0);
      chk("reset rsp_err",   32'(g_err(s[0])),       32'd0);
      chk("reset rsp_rdata", g_rdata(s[0]),          32'h0);
    end
    rst = 1'b0;

    foreach (vecs[i]) begin
      txn(1'b0, 2, vecs[i], $sformatf("vec%0d", i));
    end

    // Response held under back-pressure; a competing request must be ignored.
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0000, 4'hF);
    wait_rsp(1'b0, lat);
    chk("hold latency", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      chk("hold rsp_valid", 32'(b0.rsp_valid), 32'd1);
      chk("hold rdata",     b0.rsp_rdata,      32'hDEAD_BEAA);
      chk("hold err",       32'(b0.rsp_err),   32'd0);
      chk("hold req_ready", 32'(b0.req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    release_rsp(1'b0, "hold");
    txn(1'b0, 2, '{1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEAA, 1'b0}, "hold reload");

    // Reset during BUSY drops the store (WAIT_CYC=2).
    store_with_reset(1'b0, 32'h0000_0020, 32'h5555_5555, "rst2");
    txn(1'b0, 2, '{1'b0, 32'h0000_0020, 32'h0, 4'hF, 32'h0BAD_CAFE, 1'b0}, "rst2 reload");

    // Same with zero wait states: one edge from accept to response.
    txn(1'b1, 0, '{1'b1, 32'h0000_0020, 32'h0BAD_CAFE, 4'hF, 32'h0, 1'b0}, "w0 store");
    txn(1'b1, 0, '{1'b0, 32'h0000_0020, 32'h0, 4'hF, 32'h0BAD_CAFE, 1'b0}, "w0 load");
    store_with_reset(1'b1, 32'h0000_0020, 32'h5555_5555, "rst0");
    txn(1'b1, 0, '{1'b0, 32'h0000_0020, 32'h0, 4'hF, 32'h0BAD_CAFE, 1'b0}, "rst0 reload");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
